tratador_botoes: RTL and testbench
==================================

Name: tratador_botoes

Overview:
- Input-conditioning stage directly upstream of the Tamagotchi state controller (controlador_estados).
- Turns the two raw, bouncing, asynchronous board push-buttons into clean single-cycle b1/b2 command pulses.
- A "both buttons" command (enter/leave DANDO_AULA) is recognised when the second button is pressed within a short window after the first. In that case b1 and b2 pulse in the same cycle.
- Also exports the debounced button levels for status LEDs.

Parameters:
- CICLOS_DEBOUNCE, 3, consecutive stable clk cycles required before a debounced level changes (>=1).
- JANELA_COMBO, 5, cycles after a first press during which a press of the other button forms a combined command (>=1).
- ATIVO_BAIXO, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock (100 Hz in simulation, 10 ms period).
- rst  input  1  asynchronous, active-high reset.
- btn1_raw  input  1  raw button 1, asynchronous to clk.
- btn2_raw  input  1  raw button 2, asynchronous to clk.
- b1  output  1  one-cycle command pulse, button 1 (to controlador_estados.b1).
- b2  output  1  one-cycle command pulse, button 2 (to controlador_estados.b2).
- nivel1  output  1  debounced pressed level of button 1 (1 = pressed).
- nivel2  output  1  debounced pressed level of button 2 (1 = pressed).

Behaviour:
- Reset (async, rst=1):
  - b1=0, b2=0, nivel1=0, nivel2=0.
  - Synchroniser flops are set to the "released" level.
  - Debounce counters cleared; FSM goes to OCIOSO.
  - Outputs hold these values for as long as rst is high.
  - Reset mid-operation discards any pending window or pulse; no pulse is ever emitted as a result of reset release.
- Synchronisation: each raw input passes through a 2-flop synchroniser, then is polarity-normalised per ATIVO_BAIXO to s (1 = pressed).
- Debounce, per button:
  - Counter increments while s != nivel and clears whenever s == nivel.
  - When s != nivel for CICLOS_DEBOUNCE consecutive edges, nivel <= s and the counter clears.
  - Net latency: nivel changes exactly CICLOS_DEBOUNCE+2 edges after the first edge that samples a stable new raw level.
  - A glitch shorter than CICLOS_DEBOUNCE synchronised cycles produces no change.
- Press event: pN = nivelN & ~nivelN_q, where nivelN_q is a 1-cycle delayed copy. There is no event on release.
- FSM states: OCIOSO, ESPERA1, ESPERA2, SOLTAR. A window counter runs 0..JANELA_COMBO-1.
- OCIOSO:
  - p1&p2 -> b1=b2=1 next cycle, go to SOLTAR.
  - p1 -> ESPERA1, counter=0.
  - p2 -> ESPERA2, counter=0.
- ESPERA1:
  - p2 -> b1=b2=1 next cycle, go to SOLTAR.
  - Otherwise, when counter==JANELA_COMBO-1 -> b1=1 only, go to SOLTAR.
  - Otherwise counter++.
  - Releasing button 1 inside the window does not cancel the pending b1.
- ESPERA2: mirror of ESPERA1 with the buttons swapped.
- SOLTAR: stays until nivel1==0 and nivel2==0, then goes to OCIOSO. Press events seen in SOLTAR are ignored. Holding a button therefore never repeats a command.
- Outputs:
  - b1 and b2 are registered, high for exactly one cycle per command.
  - Never more than one command per press sequence.
- Timing, with the first-button debounced rise at edge E:
  - Single command is visible after edge E+1+JANELA_COMBO.
  - Combined command is visible one edge after the second button's debounced rise.
- Width rules:
  - Debounce counter width is $clog2(CICLOS_DEBOUNCE+1).
  - Window counter width is $clog2(JANELA_COMBO+1).
  - Neither counter wraps; both saturate or clear as described above.

Test Plan:
- Run all scenarios with CICLOS_DEBOUNCE=3, JANELA_COMBO=5, ATIVO_BAIXO=1, 10 ms clock.
- Reset: assert rst for 2 cycles with both raw=0 (pressed) -> b1=b2=nivel1=nivel2=0 during reset. After release: nivel1=nivel2=1 at edge 5; FSM sees a simultaneous press, so exactly one b1&b2 pulse follows.
- Clean single press: btn1_raw 1->0 held 200 ms, btn2_raw=1 -> nivel1=1 at edge 5. Exactly one b1 pulse (b2=0) at edge 11. No further pulses while held or after release.
- Bounce rejection: btn1_raw toggles every cycle for 8 cycles then returns to 1 -> nivel1 stays 0, b1/b2 never pulse. The same glitch, 2 cycles long, is also rejected.
- Combined command: btn1 pressed, then btn2 pressed 3 cycles later -> single cycle with b1=1 and b2=1, one edge after nivel2 rises. Repeating with btn2 pressed 7 cycles later -> b1-only pulse, with the btn2 press ignored in SOLTAR.
- Hold/repeat and release gating: hold both 3 s, release, then press btn2 alone -> exactly two commands total: b1&b2, then b2 only.
- Reset mid-window: press btn1, assert rst 2 cycles into ESPERA1 -> no b1 pulse. After rst drops with buttons released, the FSM is in OCIOSO and the next press behaves as in the clean single-press scenario.

Source files
------------

// File: rtl/tratador_botoes.sv
// tratador_botoes: synchronises, debounces and pairs two push-buttons into b1/b2 command pulses
module tratador_botoes #(
    parameter int CICLOS_DEBOUNCE = 3,
    parameter int JANELA_COMBO    = 5,
    parameter int ATIVO_BAIXO     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic b1,
    output logic b2,
    output logic nivel1,
    output logic nivel2
);
    localparam int DW = $clog2(CICLOS_DEBOUNCE + 1);
    localparam int JW = $clog2(JANELA_COMBO + 1);
    localparam logic INV = (ATIVO_BAIXO != 0);
    localparam logic [DW-1:0] DMAX = DW'(CICLOS_DEBOUNCE - 1);
    localparam logic [JW-1:0] JMAX = JW'(JANELA_COMBO - 1);
    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] ESPERA1 = 2'd1;
    localparam logic [1:0] ESPERA2 = 2'd2;
    localparam logic [1:0] SOLTAR  = 2'd3;

    logic [1:0] sync1, sync2, s, nivel, nivel_q, p;
    logic [DW-1:0] dcnt [2];
    logic [1:0] estado;
    logic [JW-1:0] jcnt;

    assign s = sync2 ^ {2{INV}};
    assign p = nivel & ~nivel_q;
    assign nivel1 = nivel[0];
    assign nivel2 = nivel[1];

    // two-flop synchroniser, resting at the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= {2{INV}};
            sync2 <= {2{INV}};
        end else begin
            sync1 <= {btn2_raw, btn1_raw};
            sync2 <= sync1;
        end
    end

    // debounce: level follows s only after it differs for CICLOS_DEBOUNCE edges in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nivel   <= '0;
            nivel_q <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            nivel_q <= nivel;
            for (int i = 0; i < 2; i++) begin
                if (s[i] == nivel[i]) dcnt[i] <= '0;
                else if (dcnt[i] == DMAX) begin
                    nivel[i] <= s[i];
                    dcnt[i]  <= '0;
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end

    // command FSM: pair presses inside the window, then wait for both buttons released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
            jcnt   <= '0;
            b1     <= 1'b0;
            b2     <= 1'b0;
        end else begin
            b1 <= 1'b0;
            b2 <= 1'b0;
            case (estado)
                OCIOSO: begin
                    jcnt <= '0;
                    if (&p) begin
                        b1 <= 1'b1;
                        b2 <= 1'b1;
                        estado <= SOLTAR;
                    end else if (p[0]) estado <= ESPERA1;
                    else if (p[1]) estado <= ESPERA2;
                end
                ESPERA1: begin
                    if (p[1]) begin
                        b1 <= 1'b1;
                        b2 <= 1'b1;
                        estado <= SOLTAR;
                    end else if (jcnt == JMAX) begin
                        b1 <= 1'b1;
                        estado <= SOLTAR;
                    end else jcnt <= jcnt + 1'b1;
                end
                ESPERA2: begin
                    if (p[0]) begin
                        b1 <= 1'b1;
                        b2 <= 1'b1;
                        estado <= SOLTAR;
                    end else if (jcnt == JMAX) begin
                        b2 <= 1'b1;
                        estado <= SOLTAR;
                    end else jcnt <= jcnt + 1'b1;
                end
                default: if (~|nivel) estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_tratador_botoes.sv
// tb_tratador_botoes: vector table plus directed multi-cycle sequences for tratador_botoes
`timescale 1ms/1us
module tb_tratador_botoes;
    logic clk = 0, rst = 1, btn1_raw = 0, btn2_raw = 0;
    logic b1, b2, nivel1, nivel2;
    int checks = 0, failures = 0;
    int cyc = 0, nboth = 0, n1 = 0, n2 = 0, last = -1;
    bit seen1 = 0;

    typedef struct { bit rst, r1, r2; logic [3:0] e; } vec_t;
    vec_t v[$];

    tratador_botoes #(.CICLOS_DEBOUNCE(3), .JANELA_COMBO(5), .ATIVO_BAIXO(1)) dut (
        .clk(clk), .rst(rst), .btn1_raw(btn1_raw), .btn2_raw(btn2_raw),
        .b1(b1), .b2(b2), .nivel1(nivel1), .nivel2(nivel2)
    );

    always #5 clk = ~clk;

    function automatic void add(bit r, bit a, bit b, logic [3:0] e, int n = 1);
        vec_t x;
        x.rst = r; x.r1 = a; x.r2 = b; x.e = e;
        for (int i = 0; i < n; i++) v.push_back(x);
    endfunction

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (nivel1) seen1 = 1;
            if (b1 | b2) begin
                last = cyc;
                if (b1 & b2) nboth++;
                else if (b1) n1++;
                else n2++;
            end
        end
    endtask

    task automatic clr();
        cyc = 0; nboth = 0; n1 = 0; n2 = 0; last = -1; seen1 = 0;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // {b1,b2,nivel1,nivel2}: reset with both pressed, then release
        add(1, 0, 0, 4'b0000, 2);
        add(0, 0, 0, 4'b0000, 4);
        add(0, 0, 0, 4'b0011);
        add(0, 0, 0, 4'b1111);
        add(0, 0, 0, 4'b0011, 3);
        add(0, 1, 1, 4'b0011, 4);
        add(0, 1, 1, 4'b0000, 4);
        // clean single press of button 1 held 200 ms
        add(0, 0, 1, 4'b0000, 4);
        add(0, 0, 1, 4'b0010, 6);
        add(0, 0, 1, 4'b1010);
        add(0, 0, 1, 4'b0010, 9);
        add(0, 1, 1, 4'b0010, 4);
        add(0, 1, 1, 4'b0000, 5);
        rst = 1; btn1_raw = 0; btn2_raw = 0;
        #1;
        chk("async_reset_outputs", {b1, b2, nivel1, nivel2}, 0);
        foreach (v[i]) begin
            rst = v[i].rst; btn1_raw = v[i].r1; btn2_raw = v[i].r2;
            tick();
            chk($sformatf("vec%0d", i), {b1, b2, nivel1, nivel2}, v[i].e);
        end

        // bounce: toggling every cycle never settles
        clr();
        for (int i = 0; i < 8; i++) begin btn1_raw = i[0]; tick(); end
        btn1_raw = 1; tick(10);
        chk("bounce_nivel1", seen1, 0);
        chk("bounce_pulses", nboth + n1 + n2, 0);
        clr();
        btn1_raw = 0; tick(2); btn1_raw = 1; tick(10);
        chk("glitch_nivel1", seen1, 0);
        chk("glitch_pulses", nboth + n1 + n2, 0);

        // combined command: btn2 three cycles after btn1
        clr();
        btn1_raw = 0; tick(3); btn2_raw = 0; tick(17);
        chk("combo_both", nboth, 1);
        chk("combo_single", n1 + n2, 0);
        chk("combo_edge", last, 9);
        btn1_raw = 1; btn2_raw = 1; tick(10);

        // btn2 seven cycles later: window already expired
        clr();
        btn1_raw = 0; tick(7); btn2_raw = 0; tick(18);
        btn1_raw = 1; btn2_raw = 1; tick(10);
        chk("late_b1", n1, 1);
        chk("late_b2", n2, 0);
        chk("late_both", nboth, 0);
        chk("late_edge", last, 11);

        // hold both 3 s, release, then btn2 alone
        clr();
        btn1_raw = 0; btn2_raw = 0; tick(300);
        btn1_raw = 1; btn2_raw = 1; tick(10);
        chk("hold_both", nboth, 1);
        cyc = 0;
        btn2_raw = 0; tick(20);
        btn2_raw = 1; tick(10);
        chk("hold_b2_edge", last, 11);
        chk("hold_total_both", nboth, 1);
        chk("hold_b2", n2, 1);
        chk("hold_b1", n1, 0);

        // reset two cycles into ESPERA1
        clr();
        btn1_raw = 0; tick(8);
        rst = 1; btn1_raw = 1; #1;
        chk("midrst_nivel1", nivel1, 0);
        tick(2);
        rst = 0; tick(15);
        chk("midrst_pulses", nboth + n1 + n2, 0);
        clr();
        btn1_raw = 0; tick(20);
        btn1_raw = 1; tick(10);
        chk("after_rst_b1", n1, 1);
        chk("after_rst_edge", last, 11);
        chk("after_rst_other", nboth + n2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
